// File: rtl/sync_fifo_wl_if.sv
// Handshake bundle for sync_fifo_wl: write side, read side, thresholds and
// error pulses. The flush input exists only when SYNC_FIFO_FLUSH_EN is defined.
interface sync_fifo_wl_if #(
    parameter int DATA_W  = 1,
    parameter int DEPTH_W = 10
);
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_full;
    logic               almost_full;
    logic [DEPTH_W:0]   wr_water_level;
    logic               rd_en;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_empty;
    logic               almost_empty;
    logic [DEPTH_W:0]   rd_water_level;
    logic [DEPTH_W:0]   af_num;
    logic [DEPTH_W:0]   ae_num;
    logic               overflow;
    logic               underflow;
`ifdef SYNC_FIFO_FLUSH_EN
    logic               flush;
`endif

    modport master (
`ifdef SYNC_FIFO_FLUSH_EN
        output flush,
`endif
        output wr_en, wr_data, rd_en, af_num, ae_num,
        input  wr_full, almost_full, wr_water_level, rd_data, rd_empty,
        input  almost_empty, rd_water_level, overflow, underflow
    );

    modport slave (
`ifdef SYNC_FIFO_FLUSH_EN
        input  flush,
`endif
        input  wr_en, wr_data, rd_en, af_num, ae_num,
        output wr_full, almost_full, wr_water_level, rd_data, rd_empty,
        output almost_empty, rd_water_level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_wl.sv
// sync_fifo_wl: parametrised single-clock FIFO with block-RAM storage,
// registered flags, programmable almost-full/almost-empty thresholds,
// optional first-word-fall-through read and overflow/underflow pulses.
// Optional synchronous flush input enabled by SYNC_FIFO_FLUSH_EN.
module sync_fifo_wl #(
    parameter int DATA_W  = 1,
    parameter int DEPTH_W = 10,
    parameter int FWFT    = 0
) (
    input  logic          clk,
    input  logic          rst,
    sync_fifo_wl_if.slave f
);
    localparam int CAP = 1 << DEPTH_W;
    typedef logic [DEPTH_W:0] cnt_t;
    localparam cnt_t ONE      = cnt_t'(1);
    localparam cnt_t FULL_CNT = cnt_t'(CAP);

    logic [DATA_W-1:0] mem [CAP];
    cnt_t              wr_ptr, rd_ptr, cnt, cnt_nxt;
    logic              wr_acc, rd_acc, clr;
    logic              full_q, af_q, ae_q, empty_q, ovf_q, udf_q;
    logic [DATA_W-1:0] rd_q;

`ifdef SYNC_FIFO_FLUSH_EN
    assign clr = f.flush;
`else
    assign clr = 1'b0;
`endif

    // A flush cycle ignores both requests, so neither side is accepted.
    assign wr_acc = f.wr_en && !full_q  && !clr;
    assign rd_acc = f.rd_en && !empty_q && !clr;

    // Occupancy after this edge; every flag is registered from it.
    always_comb begin
        cnt_nxt = cnt;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = cnt + ONE;
            2'b01:   cnt_nxt = cnt - ONE;
            default: cnt_nxt = cnt;
        endcase
    end

    // Storage write port; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_ptr[DEPTH_W-1:0]] <= f.wr_data;
    end

    // Write pointer, occupancy and count-derived flags. Full is taken from
    // the count so the prefetched FWFT words are included in capacity.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            cnt    <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ae_q   <= 1'b1;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + ONE;
            cnt    <= cnt_nxt;
            full_q <= (cnt_nxt == FULL_CNT);
            af_q   <= (cnt_nxt >= f.af_num);
            ae_q   <= (cnt_nxt <= f.ae_num);
            ovf_q  <= f.wr_en && full_q;
            udf_q  <= f.rd_en && empty_q;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            // Standard read: RAM output register loads on the accepting edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_ptr  <= '0;
                    rd_q    <= '0;
                    empty_q <= 1'b1;
                end else if (clr) begin
                    rd_ptr  <= '0;
                    empty_q <= 1'b1;
                end else begin
                    if (rd_acc) begin
                        rd_q   <= mem[rd_ptr[DEPTH_W-1:0]];
                        rd_ptr <= rd_ptr + ONE;
                    end
                    empty_q <= (cnt_nxt == '0);
                end
            end
        end else begin : g_fwft
            // Two-stage prefetch: RAM read register (mid) feeds the output
            // register. rd_ptr tracks RAM reads, not user pops.
            logic              mid_vld, out_vld, out_load, ram_rd;
            logic [DATA_W-1:0] mid_q;

            // Advance the pipeline whenever the downstream stage has room.
            always_comb begin
                out_load = mid_vld && (!out_vld || rd_acc);
                ram_rd   = (wr_ptr != rd_ptr) && (!mid_vld || out_load);
            end

            // Prefetch pipeline state; rd_data holds through flush.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_ptr  <= '0;
                    mid_vld <= 1'b0;
                    out_vld <= 1'b0;
                    mid_q   <= '0;
                    rd_q    <= '0;
                end else if (clr) begin
                    rd_ptr  <= '0;
                    mid_vld <= 1'b0;
                    out_vld <= 1'b0;
                end else begin
                    if (ram_rd) begin
                        mid_q  <= mem[rd_ptr[DEPTH_W-1:0]];
                        rd_ptr <= rd_ptr + ONE;
                    end
                    mid_vld <= ram_rd || (mid_vld && !out_load);
                    if (out_load)
                        rd_q <= mid_q;
                    out_vld <= out_load || (out_vld && !rd_acc);
                end
            end

            assign empty_q = !out_vld;
        end
    endgenerate

    assign f.wr_full        = full_q;
    assign f.almost_full    = af_q;
    assign f.almost_empty   = ae_q;
    assign f.rd_empty       = empty_q;
    assign f.wr_water_level = cnt;
    assign f.rd_water_level = cnt;
    assign f.rd_data        = rd_q;
    assign f.overflow       = ovf_q;
    assign f.underflow      = udf_q;
endmodule

// File: tb/tb_sync_fifo_wl.sv
// Bench for sync_fifo_wl: one standard-read and one FWFT instance, both 8x16,
// checked against queue-based reference models.
module tb_sync_fifo_wl;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CAP = 16;
    localparam int AF  = 12;
    localparam int AE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst0, rst1;

    sync_fifo_wl_if #(.DATA_W(DW), .DEPTH_W(AW)) b0 ();
    sync_fifo_wl_if #(.DATA_W(DW), .DEPTH_W(AW)) b1 ();

    sync_fifo_wl #(.DATA_W(DW), .DEPTH_W(AW), .FWFT(0)) u0 (.clk(clk), .rst(rst0), .f(b0));
    sync_fifo_wl #(.DATA_W(DW), .DEPTH_W(AW), .FWFT(1)) u1 (.clk(clk), .rst(rst1), .f(b1));

    int checks   = 0;
    int failures = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_rd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full output check of the standard-read instance against its model.
    task automatic chk0(input logic ovf, input logic udf);
        chk("rd_data0", 32'(b0.rd_data), 32'(exp_rd0));
        chk("rd_empty0", 32'(b0.rd_empty), 32'(q0.size() == 0));
        chk("wr_full0", 32'(b0.wr_full), 32'(q0.size() == CAP));
        chk("wr_wl0", 32'(b0.wr_water_level), q0.size());
        chk("rd_wl0", 32'(b0.rd_water_level), q0.size());
        chk("af0", 32'(b0.almost_full), 32'(q0.size() >= AF));
        chk("ae0", 32'(b0.almost_empty), 32'(q0.size() <= AE));
        chk("ovf0", 32'(b0.overflow), 32'(ovf));
        chk("udf0", 32'(b0.underflow), 32'(udf));
    endtask

    // One cycle on the standard-read instance with model update and check.
    task automatic cyc0(input logic we, input logic [7:0] wd, input logic re);
        logic wa, ra;
        b0.wr_en = we; b0.wr_data = wd; b0.rd_en = re;
        wa = we && (q0.size() < CAP);
        ra = re && (q0.size() > 0);
        step();
        if (ra) exp_rd0 = q0.pop_front();
        if (wa) q0.push_back(wd);
        chk0(we && !wa, re && !ra);
        b0.wr_en = 1'b0; b0.rd_en = 1'b0;
    endtask

    // One cycle on the FWFT instance; head word must be visible when not empty.
    task automatic cyc1(input logic we, input logic [7:0] wd, input logic re);
        logic wa, pre_empty;
        b1.wr_en = we; b1.wr_data = wd; b1.rd_en = re;
        if (q1.size() == 0) chk("fwft_empty_when_none", 32'(b1.rd_empty), 32'd1);
        if (!b1.rd_empty && q1.size() > 0) chk("fwft_head", 32'(b1.rd_data), 32'(q1[0]));
        pre_empty = b1.rd_empty;
        wa = we && (q1.size() < CAP);
        step();
        if (re && !pre_empty) void'(q1.pop_front());
        if (wa) q1.push_back(wd);
        chk("fwft_wl", 32'(b1.rd_water_level), q1.size());
        chk("fwft_af", 32'(b1.almost_full), 32'(q1.size() >= AF));
        chk("fwft_ae", 32'(b1.almost_empty), 32'(q1.size() <= AE));
        chk("fwft_ovf", 32'(b1.overflow), 32'(we && !wa));
        chk("fwft_udf", 32'(b1.underflow), 32'(re && pre_empty));
        b1.wr_en = 1'b0; b1.rd_en = 1'b0;
    endtask

    initial begin
        int popped, wn, i;
        logic we, re, pre_empty;
        logic [7:0] wd;

        b0.wr_en = 0; b0.wr_data = 0; b0.rd_en = 0; b0.af_num = 5'(AF); b0.ae_num = 5'(AE);
        b1.wr_en = 0; b1.wr_data = 0; b1.rd_en = 0; b1.af_num = 5'd0;   b1.ae_num = 5'(AE);
`ifdef SYNC_FIFO_FLUSH_EN
        b0.flush = 0; b1.flush = 0;
`endif
        rst0 = 1; rst1 = 1;
        @(negedge clk);
        step();
        exp_rd0 = 8'h00;
        chk0(1'b0, 1'b0);
        chk("af1_in_rst", 32'(b1.almost_full), 32'd0);
        chk("empty1_in_rst", 32'(b1.rd_empty), 32'd1);
        rst0 = 0; rst1 = 0;
        step();
        chk("af1_zero_thr", 32'(b1.almost_full), 32'd1);
        b1.af_num = 5'(AF);

        // fill to full, one rejected write, then drain in order
        for (int k = 0; k < 16; k++) cyc0(1'b1, 8'(k), 1'b0);
        cyc0(1'b1, 8'hFF, 1'b0);
        cyc0(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) cyc0(1'b0, 8'h00, 1'b1);
        // read while empty
        cyc0(1'b0, 8'h00, 1'b1);
        cyc0(1'b0, 8'h00, 1'b0);
        // full with both requests
        for (int k = 0; k < 16; k++) cyc0(1'b1, 8'($urandom), 1'b0);
        cyc0(1'b1, 8'h5A, 1'b1);
        for (int k = 0; k < 15; k++) cyc0(1'b0, 8'h00, 1'b1);
        // empty with both requests
        cyc0(1'b1, 8'h3C, 1'b1);
        cyc0(1'b0, 8'h00, 1'b1);
        // pointer wrap at half occupancy
        for (int k = 0; k < 8; k++) cyc0(1'b1, 8'($urandom), 1'b0);
        for (int k = 0; k < 48; k++) cyc0(1'b1, 8'($urandom), 1'b1);
        // random traffic
        for (int k = 0; k < 150; k++)
            cyc0(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        // reset mid-operation at count 9
        while (q0.size() > 0) cyc0(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 9; k++) cyc0(1'b1, 8'($urandom), 1'b0);
        rst0 = 1; b0.wr_en = 1; b0.wr_data = 8'hEE; b0.rd_en = 1;
        step();
        q0.delete();
        exp_rd0 = 8'h00;
        chk0(1'b0, 1'b0);
        rst0 = 0; b0.wr_en = 0; b0.rd_en = 0;
        cyc0(1'b0, 8'h00, 1'b0);
`ifdef SYNC_FIFO_FLUSH_EN
        for (int k = 0; k < 10; k++) cyc0(1'b1, 8'($urandom), 1'b0);
        cyc0(1'b0, 8'h00, 1'b1);
        b0.flush = 1; b0.wr_en = 1; b0.rd_en = 1;
        step();
        q0.delete();
        chk0(1'b0, 1'b0);
        b0.flush = 0; b0.wr_en = 0; b0.rd_en = 0;
        cyc0(1'b1, 8'h77, 1'b0);
        cyc0(1'b0, 8'h00, 1'b1);
`endif

        // FWFT: single word latency
        b1.wr_en = 1; b1.wr_data = 8'hA5;
        step();
        b1.wr_en = 0;
        q1.push_back(8'hA5);
        chk("fwft_lat_n", 32'(b1.rd_empty), 32'd1);
        step();
        chk("fwft_lat_n1", 32'(b1.rd_empty), 32'd1);
        step();
        chk("fwft_lat_n2_empty", 32'(b1.rd_empty), 32'd0);
        chk("fwft_lat_n2_data", 32'(b1.rd_data), 32'h0A5);
        chk("fwft_lat_wl", 32'(b1.rd_water_level), 32'd1);

        // FWFT: 20 streamed words, continuous reads once two are queued
        popped = 0; wn = 0; i = 0;
        while (i < 40 && popped < 21) begin
            we = (wn < 20); wd = 8'($urandom); re = (i >= 2);
            b1.wr_en = we; b1.wr_data = wd; b1.rd_en = re;
            if (re) begin
                chk("stream_nonempty", 32'(b1.rd_empty), 32'd0);
                if (q1.size() > 0) chk("stream_data", 32'(b1.rd_data), 32'(q1[0]));
            end
            pre_empty = b1.rd_empty;
            step();
            if (re && !pre_empty) begin void'(q1.pop_front()); popped++; end
            if (we) begin q1.push_back(wd); wn++; end
            chk("stream_udf", 32'(b1.underflow), 32'd0);
            chk("stream_wl", 32'(b1.rd_water_level), q1.size());
            i++;
        end
        b1.wr_en = 0; b1.rd_en = 0;
        chk("stream_pops", popped, 32'd21);
        step();
        chk("stream_drained", 32'(b1.rd_empty), 32'd1);

        // FWFT: random traffic including full and empty corners
        for (int k = 0; k < 200; k++)
            cyc1(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0));
        for (int k = 0; k < 200; k++)
            cyc1(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
